wb_trace_buffer: RTL and testbench
==================================

// Module: wb_trace_buffer
// PURPOSE
//  Synthesisable successor to the bench-side trace file dump: captures core trace beats (trace_valid/trace_data)
//  into an on-chip circular buffer, readable over a Wishbone classic slave. Adds a no-progress watchdog,
//  stop-on-trap and wrap/stop-when-full modes. Sits beside the CPU wrapper on the wb_clk domain.
// PARAMETERS
//  DATA_W  36   trace beat width, 1..64
//  DEPTH   256  entries, power of 2, >=4
//  TS_W    32   timestamp width (used only with WB_TRACE_TIMESTAMP_EN), 1..32
// PORTS
//  wb_clk       in   1       sole clock, rising edge
//  wb_rst       in   1       synchronous, active-high reset
//  trace_valid  in   1       trace beat qualifier
//  trace_data   in   DATA_W  trace beat
//  trap         in   1       core trap indication
//  wbs_cyc_i    in   1       WB cycle
//  wbs_stb_i    in   1       WB strobe
//  wbs_we_i     in   1       WB write enable
//  wbs_adr_i    in   3       WB word address
//  wbs_dat_i    in   32      WB write data
//  wbs_dat_o    out  32      WB read data
//  wbs_ack_o    out  1       WB acknowledge
//  timeout_o    out  1       sticky watchdog expiry
//  irq_o        out  1       level: STOPPED state or overflow flag set
// BEHAVIOUR
//  Reset: all outputs 0; pointers/count 0; CTRL=0; TIMEOUT_LIMIT=0; state IDLE; flags cleared.
//  WB: access accepted when cyc&stb&!ack; ack=1 exactly next cycle, then 0 (one wait state, no stalls).
//   Write/pop side effects and dat_o capture happen at the accepting edge; dat_o holds until next accept.
//  Map (word addr): 0 CTRL rw [0]enable [1]clear(self-clearing, reads 0) [2]stop_on_trap [3]wrap
//   1 STATUS ro [0]empty [1]full [2]overflow [3]stopped [4]timeout [31:16]count
//   2 DATA_LO ro: read pops oldest entry, returns data[31:0], latches data[63:32] (and ts) into shadows
//   3 DATA_HI ro: shadow of upper bits, zero-extended; no pop    4 TS ro: timestamp shadow
//   5 TIMEOUT_LIMIT rw: watchdog cycles, 0 = disabled    6 CYCLES ro: free-running cycle count [31:0]
//   7 reserved: reads 0, writes ignored. Write to ro address: ignored, still acked.
//  FSM: IDLE -(enable=1)-> ARMED -(stop cond)-> STOPPED -(enable=0)-> IDLE; any state -(clear)-> IDLE,
//   pointers/count/overflow/timeout/watchdog zeroed, CTRL.enable forced 0.
//  ARMED: each trace_valid writes one entry. Stop conds: trap&stop_on_trap; watchdog expiry; full&!wrap.
//  Watchdog: counter resets on trace_valid or leaving ARMED, increments otherwise in ARMED; ==LIMIT (nonzero)
//   -> timeout_o=1 sticky, STOPPED.
//  Boundaries:
//   - pop when empty: returns 0, pointers unchanged, shadows zeroed
//   - full, wrap=1, valid w/o pop: overwrite oldest, rd_ptr advances, count stays DEPTH, overflow=1 sticky
//   - full, wrap=0: final write fills, then STOPPED same edge; later beats dropped, overflow=1
//   - capture and pop same edge: both occur, count unchanged; when full this is not overflow
//   - trap and valid same edge: beat captured, then STOPPED
//   - clear and valid same edge: clear wins, beat dropped
//   - STOPPED/IDLE: beats ignored; reads still pop. wb_rst mid-access: ack drops to 0 next edge.
//  Pointers are log2(DEPTH) bits, wrap naturally; count is log2(DEPTH)+1 bits.
// CONFIGURATION
//  WB_TRACE_TIMESTAMP_EN defined: each entry stores CYCLES[TS_W-1:0] at capture; addr 4 returns it,
//   zero-extended. Undefined: no timestamp storage (RAM width DATA_W), addr 4 reads 0.
// STRUCTURE
//  Package nanorv32_trace_pkg: register offsets, CTRL/STATUS bit indices, FSM state encoding.
//  Sub-module trace_ram: simple dual-port RAM (1 write, 1 read, DEPTH x entry width), read-during-write
//   returns old data; top handles pointers, FSM, watchdog, WB decode.
// TESTING
//  1. Enable, 3 beats 0x1_0000_0001..3, pop x3 -> DATA_LO 1,2,3, DATA_HI 1; 4th pop -> 0, empty=1.
//  2. DEPTH=4, wrap=1, 6 beats 1..6 -> count=4, overflow=1, pops return 3,4,5,6.
//  3. DEPTH=4, wrap=0, 6 beats -> stopped=1, irq_o=1, pops return 1..4.
//  4. LIMIT=10, no beats after enable -> timeout_o=1 on 10th ARMED cycle, state STOPPED.
//  5. stop_on_trap=1, trap with valid beat 0x55 -> 0x55 captured, later beats ignored; clear -> empty, IDLE.
//  6. With macro: beats at CYCLES=100,105 -> TS reads 100,105; without macro TS reads 0.

Source files
------------

// File: rtl/nanorv32_trace_pkg.sv
// Shared definitions for the Wishbone trace buffer: register map, CTRL/STATUS
// bit positions and the capture FSM encoding.
package nanorv32_trace_pkg;

    localparam logic [2:0] REG_CTRL    = 3'd0;
    localparam logic [2:0] REG_STATUS  = 3'd1;
    localparam logic [2:0] REG_DATA_LO = 3'd2;
    localparam logic [2:0] REG_DATA_HI = 3'd3;
    localparam logic [2:0] REG_TS      = 3'd4;
    localparam logic [2:0] REG_LIMIT   = 3'd5;
    localparam logic [2:0] REG_CYCLES  = 3'd6;

    localparam int CTRL_ENABLE    = 0;
    localparam int CTRL_CLEAR     = 1;
    localparam int CTRL_STOP_TRAP = 2;
    localparam int CTRL_WRAP      = 3;

    localparam int STAT_EMPTY     = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_OVERFLOW  = 2;
    localparam int STAT_STOPPED   = 3;
    localparam int STAT_TIMEOUT   = 4;
    localparam int STAT_COUNT_LSB = 16;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_STOPPED = 2'd2
    } trace_state_e;

    typedef struct packed {
        logic wrap;
        logic stop_on_trap;
        logic enable;
    } ctrl_t;

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port trace storage: one synchronous write port, one asynchronous
// read port, so a read at the written address in the same cycle sees old data.
module trace_ram #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 36
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/wb_trace_buffer.sv
// Circular trace capture buffer with a Wishbone classic slave, no-progress watchdog
// and stop-on-trap. Define WB_TRACE_TIMESTAMP_EN to store a cycle timestamp per entry.
module wb_trace_buffer
    import nanorv32_trace_pkg::*;
#(
    parameter int DATA_W = 36,
    parameter int DEPTH  = 256,
    parameter int TS_W   = 32
) (
    input  logic              wb_clk,
    input  logic              wb_rst,
    input  logic              trace_valid,
    input  logic [DATA_W-1:0] trace_data,
    input  logic              trap,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [2:0]        wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic [31:0]       wbs_dat_o,
    output logic              wbs_ack_o,
    output logic              timeout_o,
    output logic              irq_o
);

    localparam int AW = $clog2(DEPTH);
`ifdef WB_TRACE_TIMESTAMP_EN
    localparam int ENT_W = DATA_W + TS_W;
`else
    localparam int ENT_W = DATA_W;
`endif
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    trace_state_e    state;
    ctrl_t           ctrl;
    logic [31:0]     limit;
    logic [31:0]     cycles;
    logic [31:0]     wd_cnt;
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count, count_nxt;
    logic            overflow, timeout;
    logic            ack;
    logic [31:0]     dat_q;
    logic [31:0]     hi_shadow, ts_shadow;

    logic [ENT_W-1:0] ram_wdata, ram_rdata;
    logic [63:0]      beat64;
    logic [31:0]      ts_rd;
    logic [31:0]      rd_mux;
    logic [31:0]      wd_next;

    logic accept, wr_acc, rd_acc, clear, pop_req, pop;
    logic empty, full, armed;
    logic cap, overwrite, drop_full;
    logic wd_expire, trap_stop, full_stop, stop;

    // Bus decode: one access per two cycles, ack always follows acceptance.
    assign accept  = wbs_cyc_i && wbs_stb_i && !ack;
    assign wr_acc  = accept && wbs_we_i;
    assign rd_acc  = accept && !wbs_we_i;
    assign clear   = wr_acc && (wbs_adr_i == REG_CTRL) && wbs_dat_i[CTRL_CLEAR];
    assign pop_req = rd_acc && (wbs_adr_i == REG_DATA_LO);

    assign empty = (count == '0);
    assign full  = (count == CNT_FULL);
    assign armed = (state == S_ARMED);
    assign pop   = pop_req && !empty;

    // A beat into a full buffer is only accepted if it can displace something.
    assign cap       = armed && trace_valid && !clear && (!full || ctrl.wrap || pop);
    assign overwrite = cap && full && !pop;
    assign drop_full = trace_valid && !clear && (state != S_IDLE) && full && !pop && !ctrl.wrap;

    always_comb begin
        count_nxt = count;
        if (cap && !pop && !overwrite) count_nxt = count + CNT_ONE;
        else if (pop && !cap)          count_nxt = count - CNT_ONE;
    end

    assign wd_next   = wd_cnt + 32'd1;
    assign wd_expire = armed && !trace_valid && (limit != '0) && (wd_next == limit);
    assign trap_stop = armed && trap && ctrl.stop_on_trap;
    assign full_stop = armed && !ctrl.wrap && (count_nxt == CNT_FULL);
    assign stop      = trap_stop || wd_expire || full_stop;

`ifdef WB_TRACE_TIMESTAMP_EN
    assign ram_wdata = {cycles[TS_W-1:0], trace_data};
    assign ts_rd     = 32'(ram_rdata[ENT_W-1:DATA_W]);
`else
    assign ram_wdata = trace_data;
    assign ts_rd     = '0;
`endif
    assign beat64 = 64'(ram_rdata[DATA_W-1:0]);

    trace_ram #(.DEPTH(DEPTH), .WIDTH(ENT_W)) u_ram (
        .clk   (wb_clk),
        .we    (cap),
        .waddr (wr_ptr),
        .wdata (ram_wdata),
        .raddr (rd_ptr),
        .rdata (ram_rdata)
    );

    always_comb begin
        rd_mux = '0;
        case (wbs_adr_i)
            REG_CTRL:    rd_mux = {28'd0, ctrl.wrap, ctrl.stop_on_trap, 1'b0, ctrl.enable};
            REG_STATUS:  rd_mux = {16'(count), 11'd0, timeout, state == S_STOPPED,
                                   overflow, full, empty};
            REG_DATA_LO: rd_mux = pop ? beat64[31:0] : '0;
            REG_DATA_HI: rd_mux = hi_shadow;
            REG_TS:      rd_mux = ts_shadow;
            REG_LIMIT:   rd_mux = limit;
            REG_CYCLES:  rd_mux = cycles;
            default:     rd_mux = '0;
        endcase
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state     <= S_IDLE;
            ctrl      <= '0;
            limit     <= '0;
            cycles    <= '0;
            wd_cnt    <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            timeout   <= 1'b0;
            ack       <= 1'b0;
            dat_q     <= '0;
            hi_shadow <= '0;
            ts_shadow <= '0;
        end else begin
            ack    <= accept;
            cycles <= cycles + 32'd1;

            if (accept) dat_q <= wbs_we_i ? 32'd0 : rd_mux;
            if (pop_req) begin
                hi_shadow <= pop ? beat64[63:32] : '0;
                ts_shadow <= pop ? ts_rd : '0;
            end
            if (wr_acc && wbs_adr_i == REG_LIMIT) limit <= wbs_dat_i;

            if (clear) begin
                ctrl     <= '{wrap: wbs_dat_i[CTRL_WRAP],
                              stop_on_trap: wbs_dat_i[CTRL_STOP_TRAP],
                              enable: 1'b0};
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
                overflow <= 1'b0;
                timeout  <= 1'b0;
                wd_cnt   <= '0;
                state    <= S_IDLE;
            end else begin
                if (wr_acc && wbs_adr_i == REG_CTRL)
                    ctrl <= '{wrap: wbs_dat_i[CTRL_WRAP],
                              stop_on_trap: wbs_dat_i[CTRL_STOP_TRAP],
                              enable: wbs_dat_i[CTRL_ENABLE]};
                if (cap)              wr_ptr <= wr_ptr + PTR_ONE;
                if (pop || overwrite) rd_ptr <= rd_ptr + PTR_ONE;
                count <= count_nxt;
                if (overwrite || drop_full) overflow <= 1'b1;

                wd_cnt <= (armed && !trace_valid) ? wd_next : '0;
                if (wd_expire) timeout <= 1'b1;

                case (state)
                    S_IDLE:    if (ctrl.enable) state <= S_ARMED;
                    S_ARMED:   if (stop) state <= S_STOPPED;
                               else if (!ctrl.enable) state <= S_IDLE;
                    S_STOPPED: if (!ctrl.enable) state <= S_IDLE;
                    default:   state <= S_IDLE;
                endcase
            end
        end
    end

    assign wbs_ack_o = ack;
    assign wbs_dat_o = dat_q;
    assign timeout_o = timeout;
    assign irq_o     = (state == S_STOPPED) || overflow;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Scoreboard bench for wb_trace_buffer: expected beats are queued as they are
// driven and compared as DATA_LO pops return them.
module tb_wb_trace_buffer;

    localparam int DATA_W = 36;
    localparam int DEPTH  = 4;
    localparam int TS_W   = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              trace_valid, trap;
    logic [DATA_W-1:0] trace_data;
    logic              cyc, stb, we;
    logic [2:0]        adr;
    logic [31:0]       dat_i, dat_o;
    logic              ack, timeout, irq;

    int                vectors = 0;
    int                errors  = 0;
    logic [DATA_W-1:0] sb[$];
    int unsigned       tb_cycles;

    wb_trace_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TS_W(TS_W)) dut (
        .wb_clk      (clk),
        .wb_rst      (rst),
        .trace_valid (trace_valid),
        .trace_data  (trace_data),
        .trap        (trap),
        .wbs_cyc_i   (cyc),
        .wbs_stb_i   (stb),
        .wbs_we_i    (we),
        .wbs_adr_i   (adr),
        .wbs_dat_i   (dat_i),
        .wbs_dat_o   (dat_o),
        .wbs_ack_o   (ack),
        .timeout_o   (timeout),
        .irq_o       (irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) tb_cycles <= 0;
        else     tb_cycles <= tb_cycles + 1;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "bench did not finish");
    end

    task automatic wb_access(input logic w, input logic [2:0] a, input logic [31:0] d,
                             output logic [31:0] rd);
        bit got = 0;
        @(negedge clk);
        cyc = 1; stb = 1; we = w; adr = a; dat_i = d;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (ack) begin got = 1; break; end
        end
        rd = dat_o;
        cyc = 0; stb = 0; we = 0;
        if (!got) begin
            errors++;
            $display("FAIL wb_ack_timeout adr=%0d", a);
        end
    endtask

    task automatic wb_write(input logic [2:0] a, input logic [31:0] d);
        logic [31:0] unused;
        wb_access(1'b1, a, d, unused);
    endtask

    task automatic wb_read(input logic [2:0] a, output logic [31:0] d);
        wb_access(1'b0, a, 32'd0, d);
    endtask

    task automatic send_beat(input logic [DATA_W-1:0] d, input logic t);
        @(negedge clk);
        trace_valid = 1; trace_data = d; trap = t;
        @(negedge clk);
        trace_valid = 0; trap = 0;
    endtask

    task automatic drain(input string name);
        logic [31:0]       got;
        logic [DATA_W-1:0] exp;
        while (sb.size() > 0) begin
            exp = sb.pop_front();
            wb_read(3'd2, got);
            vectors++;
            if (got !== exp[31:0]) begin
                errors++;
                $display("FAIL %s_pop got=%h exp=%h", name, got, exp[31:0]);
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] got;
        rst = 1; trace_valid = 0; trap = 0; trace_data = '0;
        cyc = 0; stb = 0; we = 0; adr = '0; dat_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({ack, timeout, irq} !== 3'b000 || dat_o !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs got=%b/%h exp=000/0", {ack, timeout, irq}, dat_o);
        end
        rst = 0;
        wb_read(3'd1, got);
        vectors++;
        if (got !== 32'h1) begin errors++; $display("FAIL reset_status got=%h exp=1", got); end
        wb_read(3'd0, got);
        vectors++;
        if (got !== 32'h0) begin errors++; $display("FAIL reset_ctrl got=%h exp=0", got); end
        wb_read(3'd5, got);
        vectors++;
        if (got !== 32'h0) begin errors++; $display("FAIL reset_limit got=%h exp=0", got); end
    endtask

    task automatic test_regs();
        logic [31:0] got;
        wb_write(3'd1, 32'hFFFF_FFFF);
        wb_read(3'd1, got);
        vectors++;
        if (got !== 32'h1) begin errors++; $display("FAIL ro_write got=%h exp=1", got); end
        wb_write(3'd7, 32'hDEAD_BEEF);
        wb_read(3'd7, got);
        vectors++;
        if (got !== 32'h0) begin errors++; $display("FAIL reserved got=%h exp=0", got); end
        wb_write(3'd5, 32'h1234);
        wb_read(3'd5, got);
        vectors++;
        if (got !== 32'h1234) begin errors++; $display("FAIL limit_rw got=%h exp=1234", got); end
        wb_write(3'd5, 32'h0);
        wb_write(3'd0, 32'hF);
        wb_read(3'd0, got);
        vectors++;
        if (got !== 32'hC) begin errors++; $display("FAIL clear_forces_en got=%h exp=c", got); end
        wb_write(3'd0, 32'h2);
    endtask

    task automatic test_basic();
        logic [31:0]       got;
        logic [DATA_W-1:0] exp;
        wb_write(3'd0, 32'h1);
        for (int i = 1; i <= 3; i++) begin
            exp = 36'h1_0000_0000 | DATA_W'(i);
            sb.push_back(exp);
            send_beat(exp, 1'b0);
        end
        wb_read(3'd1, got);
        vectors++;
        if (got !== 32'h0003_0000) begin errors++; $display("FAIL basic_status got=%h exp=30000", got); end
        while (sb.size() > 0) begin
            exp = sb.pop_front();
            wb_read(3'd2, got);
            vectors++;
            if (got !== exp[31:0]) begin errors++; $display("FAIL basic_lo got=%h exp=%h", got, exp[31:0]); end
            wb_read(3'd3, got);
            vectors++;
            if (got !== 32'(exp[DATA_W-1:32])) begin errors++; $display("FAIL basic_hi got=%h exp=1", got); end
        end
        wb_read(3'd2, got);
        vectors++;
        if (got !== 32'h0) begin errors++; $display("FAIL empty_pop got=%h exp=0", got); end
        wb_read(3'd3, got);
        vectors++;
        if (got !== 32'h0) begin errors++; $display("FAIL empty_hi got=%h exp=0", got); end
        wb_read(3'd1, got);
        vectors++;
        if (got !== 32'h1) begin errors++; $display("FAIL basic_empty got=%h exp=1", got); end
        wb_write(3'd0, 32'h2);
    endtask

    task automatic test_wrap();
        logic [31:0] got;
        wb_write(3'd0, 32'h9);
        for (int i = 1; i <= 6; i++) begin
            sb.push_back(DATA_W'(i));
            if (sb.size() > DEPTH) void'(sb.pop_front());
            send_beat(DATA_W'(i), 1'b0);
        end
        wb_read(3'd1, got);
        vectors++;
        if (got !== 32'h0004_0006) begin errors++; $display("FAIL wrap_status got=%h exp=40006", got); end
        vectors++;
        if (irq !== 1'b1) begin errors++; $display("FAIL wrap_irq got=%b exp=1", irq); end
        drain("wrap");
        wb_write(3'd0, 32'h2);
    endtask

    task automatic test_stop_full();
        logic [31:0] got;
        wb_write(3'd0, 32'h1);
        for (int i = 1; i <= 6; i++) begin
            if (sb.size() < DEPTH) sb.push_back(DATA_W'(32'h10 + i));
            send_beat(DATA_W'(32'h10 + i), 1'b0);
        end
        vectors++;
        if (irq !== 1'b1) begin errors++; $display("FAIL full_irq got=%b exp=1", irq); end
        wb_read(3'd1, got);
        vectors++;
        if (got !== 32'h0004_000E) begin errors++; $display("FAIL full_status got=%h exp=4000e", got); end
        drain("full");
        send_beat(DATA_W'(32'h77), 1'b0);
        wb_read(3'd1, got);
        vectors++;
        if (got !== 32'hD) begin errors++; $display("FAIL stopped_ignore got=%h exp=d", got); end
        wb_write(3'd0, 32'h2);
    endtask

    task automatic test_watchdog();
        logic [31:0] got;
        int n = 0;
        wb_write(3'd5, 32'd10);
        wb_write(3'd0, 32'h1);
        while (n < 50) begin
            @(negedge clk);
            n++;
            if (timeout) break;
        end
        vectors++;
        if (n !== 11) begin errors++; $display("FAIL wd_latency got=%0d exp=11", n); end
        vectors++;
        if (irq !== 1'b1) begin errors++; $display("FAIL wd_irq got=%b exp=1", irq); end
        wb_read(3'd1, got);
        vectors++;
        if (got !== 32'h19) begin errors++; $display("FAIL wd_status got=%h exp=19", got); end
        wb_write(3'd5, 32'd0);
        wb_write(3'd0, 32'h2);
        vectors++;
        if (timeout !== 1'b0) begin errors++; $display("FAIL wd_clear got=%b exp=0", timeout); end
    endtask

    task automatic test_trap();
        logic [31:0] got;
        wb_write(3'd0, 32'h5);
        sb.push_back(DATA_W'(32'h55));
        send_beat(DATA_W'(32'h55), 1'b1);
        send_beat(DATA_W'(32'h66), 1'b0);
        send_beat(DATA_W'(32'h67), 1'b0);
        wb_read(3'd1, got);
        vectors++;
        if (got !== 32'h0001_0008) begin errors++; $display("FAIL trap_status got=%h exp=10008", got); end
        vectors++;
        if (irq !== 1'b1) begin errors++; $display("FAIL trap_irq got=%b exp=1", irq); end
        drain("trap");
        send_beat(DATA_W'(32'h68), 1'b0);
        wb_write(3'd0, 32'h2);
        wb_read(3'd1, got);
        vectors++;
        if (got !== 32'h1) begin errors++; $display("FAIL trap_clear got=%h exp=1", got); end
        vectors++;
        if (irq !== 1'b0) begin errors++; $display("FAIL trap_clear_irq got=%b exp=0", irq); end
    endtask

    task automatic test_back_to_back();
        logic [31:0]       got;
        logic [DATA_W-1:0] exp;
        wb_write(3'd0, 32'h9);
        for (int i = 1; i <= 4; i++) begin
            sb.push_back(DATA_W'(32'h20 + i));
            send_beat(DATA_W'(32'h20 + i), 1'b0);
        end
        // pop and capture on the same edge while full
        @(negedge clk);
        cyc = 1; stb = 1; we = 0; adr = 3'd2;
        trace_valid = 1; trace_data = DATA_W'(32'h25);
        @(negedge clk);
        trace_valid = 0;
        got = dat_o;
        vectors++;
        if (ack !== 1'b1) begin errors++; $display("FAIL b2b_ack got=%b exp=1", ack); end
        cyc = 0; stb = 0;
        exp = sb.pop_front();
        sb.push_back(DATA_W'(32'h25));
        vectors++;
        if (got !== exp[31:0]) begin errors++; $display("FAIL b2b_pop got=%h exp=%h", got, exp[31:0]); end
        wb_read(3'd1, got);
        vectors++;
        if (got !== 32'h0004_0002) begin errors++; $display("FAIL b2b_status got=%h exp=40002", got); end
        drain("b2b");
        // clear and a beat on the same edge: the beat is lost
        send_beat(DATA_W'(32'h31), 1'b0);
        @(negedge clk);
        cyc = 1; stb = 1; we = 1; adr = 3'd0; dat_i = 32'h2;
        trace_valid = 1; trace_data = DATA_W'(32'h99);
        @(negedge clk);
        trace_valid = 0; cyc = 0; stb = 0; we = 0;
        wb_read(3'd1, got);
        vectors++;
        if (got !== 32'h1) begin errors++; $display("FAIL clear_vs_beat got=%h exp=1", got); end
        wb_read(3'd2, got);
        vectors++;
        if (got !== 32'h0) begin errors++; $display("FAIL clear_pop got=%h exp=0", got); end
    endtask

    task automatic test_timestamp();
        logic [31:0] got;
        int unsigned ts[2];
        wb_write(3'd0, 32'h1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            trace_valid = 1; trace_data = DATA_W'(32'h40 + i);
            ts[i] = tb_cycles;
            @(negedge clk);
            trace_valid = 0;
            repeat (4) @(negedge clk);
        end
        for (int i = 0; i < 2; i++) begin
            wb_read(3'd2, got);
            vectors++;
            if (got !== 32'h40 + i) begin errors++; $display("FAIL ts_data got=%h exp=%h", got, 32'h40 + i); end
            wb_read(3'd4, got);
            vectors++;
`ifdef WB_TRACE_TIMESTAMP_EN
            if (got !== ts[i]) begin errors++; $display("FAIL ts_value got=%0d exp=%0d", got, ts[i]); end
`else
            if (got !== 32'h0) begin errors++; $display("FAIL ts_value got=%0d exp=0 (cycle %0d)", got, ts[i]); end
`endif
        end
        wb_write(3'd0, 32'h2);
    endtask

    initial begin
        test_reset();
        test_regs();
        test_basic();
        test_wrap();
        test_stop_full();
        test_watchdog();
        test_trap();
        test_back_to_back();
        test_timestamp();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
